// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Latency: none (types, constants and an elaboration-time helper only).
// Backpressure: not applicable.
package uart_arb_pkg;

  localparam int DEF_N_REQ       = 4;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_TIMEOUT_CYC = 65535;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_ACC,
    WAIT_DONE,
    DONE
  } arb_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping past N_REQ-1 to 0.
// Latency: purely combinational.
// Backpressure: none; valid simply reflects whether any request is set.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0]        req,
  input  logic [idx_w(N_REQ)-1:0] ptr,
  output logic [idx_w(N_REQ)-1:0] winner,
  output logic                    valid
);

  localparam int IW = idx_w(N_REQ);

  logic [IW-1:0] idx;

  // Scan from farthest to nearest offset so the request closest to ptr wins last.
  always_comb begin
    winner = '0;
    idx    = '0;
    valid  = |req;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      idx = IW'((int'(ptr) + off) % N_REQ);
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ requesters with round-robin fairness.
// Latency: tx_start one cycle after the IDLE edge that samples req; ack one cycle after tx_rdy returns.
// Backpressure: waits in IDLE while tx_rdy=0; optional watchdog (UART_TX_ARB_TIMEOUT_EN) forces completion.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          ack,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_rdy,
  output logic [idx_w(N_REQ)-1:0]   grant_id,
  output logic                      busy,
  output logic                      err
);

  localparam int IW = idx_w(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT_CYC at least 2");
  end

  arb_state_t        state;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     pick_id;
  logic              pick_vld;
  logic [DATA_W-1:0] req_bytes [N_REQ];
  logic              timeout;

  uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_id),
    .valid  (pick_vld)
  );

  // Unpack the flat request data bus into one byte per requester.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_bytes[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign busy = (state != IDLE);

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC);

  logic [WD_W-1:0] wd;
  logic            in_wait;
  logic            leaving;

  assign in_wait = (state == WAIT_ACC) || (state == WAIT_DONE);
  assign leaving = ((state == WAIT_ACC) && !tx_rdy) || ((state == WAIT_DONE) && tx_rdy);
  assign timeout = in_wait && (wd == WD_W'(TIMEOUT_CYC - 1));

  // Watchdog: counts cycles inside one wait state, restarts on every state entry;
  // err is raised in the last wait cycle so the forced ack lands right after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd  <= '0;
      err <= 1'b0;
    end else begin
      err <= in_wait && !leaving && (wd == WD_W'(TIMEOUT_CYC - 2));
      if (!in_wait || leaving || timeout) wd <= '0;
      else                                wd <= wd + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // Transfer sequencer: arbitrate, pulse start, follow tx_rdy handshake, acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      grant_id <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      ack      <= '0;
    end else begin
      tx_start <= 1'b0;
      ack      <= '0;
      case (state)
        IDLE: begin
          if (pick_vld && tx_rdy) begin
            grant_id <= pick_id;
            tx_data  <= req_bytes[pick_id];
            tx_start <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          state <= WAIT_ACC;
        end
        WAIT_ACC: begin
          if (timeout) begin
            ack   <= N_REQ'(1) << grant_id;
            state <= DONE;
          end else if (!tx_rdy) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (timeout || tx_rdy) begin
            ack   <= N_REQ'(1) << grant_id;
            state <= DONE;
          end
        end
        DONE: begin
          ptr   <= (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
